load_align_unit: RTL

//  Sequential load-data aligner/extender between the LSU and the data-memory port of the RISC-V core.

---
 rtl/riscv_pkg.sv | 36 +++
 rtl/load_extend.sv | 30 +++
 rtl/load_align_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V load definitions: funct3 encodings, aligner FSM states and access sizes.
// Honours LOAD_MISALIGN_SPLIT_EN (adds the second-read states for split misaligned loads).
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef logic [3:0] size_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_WAIT0,
`ifdef LOAD_MISALIGN_SPLIT_EN
        S_REQ1,
        S_WAIT1,
`endif
        S_RESP
    } lau_state_t;

    // Access size in bytes; the low two funct3 bits encode it for both signed and unsigned loads.
    function automatic size_t load_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   load_size = 4'd1;
            2'b01:   load_size = 4'd2;
            2'b10:   load_size = 4'd4;
            default: load_size = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational byte/half/word/double selection from a two-word window plus sign/zero extension.
module load_extend #(
    parameter int XLEN      = 32,
    parameter int BUS_BYTES = 4,
    localparam int OFF_W    = $clog2(BUS_BYTES)
) (
    input  logic [16*BUS_BYTES-1:0] words,
    input  logic [OFF_W-1:0]        offset,
    input  logic [2:0]              funct3,
    output logic [XLEN-1:0]         result
);
    import riscv_pkg::*;

    logic [XLEN-1:0] field;

    always_comb begin
        field = XLEN'(words >> {offset, 3'b000});
        case (funct3)
            F3_LB:   result = XLEN'($signed(field[7:0]));
            F3_LH:   result = XLEN'($signed(field[15:0]));
            F3_LW:   result = XLEN'($signed(field[31:0]));
            F3_LD:   result = field;
            F3_LBU:  result = XLEN'(field[7:0]);
            F3_LHU:  result = XLEN'(field[15:0]);
            F3_LWU:  result = XLEN'(field[31:0]);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/load_align_unit.sv
// Sequential load aligner: word-aligned memory reads, field extraction, extension, valid/ready result.
// LOAD_MISALIGN_SPLIT_EN: crossing loads use two reads instead of returning an error.
module load_align_unit #(
    parameter int XLEN      = 32,
    parameter int BUS_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [XLEN-1:0]        req_addr,
    input  logic [2:0]             req_funct3,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [XLEN-1:0]        mem_req_addr,
    input  logic                   mem_rsp_valid,
    input  logic [8*BUS_BYTES-1:0] mem_rsp_data,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [XLEN-1:0]        rsp_data,
    output logic                   rsp_err
);
    import riscv_pkg::*;

    localparam int OFF_W = $clog2(BUS_BYTES);
    localparam int BUS_W = 8 * BUS_BYTES;

    lau_state_t        state, state_d;
    logic [XLEN-1:0]   addr_q;
    logic [2:0]        f3_q;
    logic              load_rsp;
    logic [XLEN-1:0]   rsp_data_d;
    logic              rsp_err_d;
    logic [OFF_W-1:0]  req_off;
    size_t             req_size;
    logic              illegal;
    logic              req_err;
    logic [XLEN-1:0]   word_addr;
    logic [2*BUS_W-1:0] ext_words;
    logic [XLEN-1:0]   ext_result;

    assign req_off  = req_addr[OFF_W-1:0];
    assign req_size = load_size(req_funct3);
    assign illegal  = (req_funct3 == 3'b111) ||
                      ((XLEN == 32) && ((req_funct3 == F3_LD) || (req_funct3 == F3_LWU)));

    assign word_addr     = {addr_q[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    assign req_ready     = (state == S_IDLE);
    assign rsp_valid     = (state == S_RESP);

`ifdef LOAD_MISALIGN_SPLIT_EN
    logic [4:0]       end_pos;
    logic             crossing;
    logic             cross_q;
    logic             capture_w0;
    logic [BUS_W-1:0] w0_q;

    assign end_pos       = 5'(req_off) + 5'(req_size);
    assign crossing      = (end_pos > 5'(BUS_BYTES));
    assign req_err       = illegal;
    assign mem_req_valid = (state == S_REQ0) || (state == S_REQ1);
    // Second read wraps modulo 2^XLEN through plain truncating addition.
    assign mem_req_addr  = (state == S_REQ1) ? word_addr + XLEN'(BUS_BYTES) : word_addr;
    assign ext_words     = (state == S_WAIT1) ? {mem_rsp_data, w0_q}
                                              : {{BUS_W{1'b0}}, mem_rsp_data};
`else
    logic misalign;

    assign misalign      = ((size_t'(req_off) & (req_size - 4'd1)) != 4'd0);
    assign req_err       = illegal || misalign;
    assign mem_req_valid = (state == S_REQ0);
    assign mem_req_addr  = word_addr;
    assign ext_words     = {{BUS_W{1'b0}}, mem_rsp_data};
`endif

    load_extend #(.XLEN(XLEN), .BUS_BYTES(BUS_BYTES)) u_extend (
        .words  (ext_words),
        .offset (addr_q[OFF_W-1:0]),
        .funct3 (f3_q),
        .result (ext_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state <= state_d;
            if (load_rsp) begin
                rsp_data <= rsp_data_d;
                rsp_err  <= rsp_err_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && req_valid) begin
            addr_q <= req_addr;
            f3_q   <= req_funct3;
`ifdef LOAD_MISALIGN_SPLIT_EN
            cross_q <= crossing;
`endif
        end
`ifdef LOAD_MISALIGN_SPLIT_EN
        if (capture_w0) w0_q <= mem_rsp_data;
`endif
    end

    always_comb begin
        state_d    = state;
        load_rsp   = 1'b0;
        rsp_data_d = ext_result;
        rsp_err_d  = 1'b0;
`ifdef LOAD_MISALIGN_SPLIT_EN
        capture_w0 = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_err) begin
                        state_d    = S_RESP;
                        load_rsp   = 1'b1;
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                    end else begin
                        state_d = S_REQ0;
                    end
                end
            end
            S_REQ0: if (mem_req_ready) state_d = S_WAIT0;
            S_WAIT0: begin
                if (mem_rsp_valid) begin
`ifdef LOAD_MISALIGN_SPLIT_EN
                    if (cross_q) begin
                        capture_w0 = 1'b1;
                        state_d    = S_REQ1;
                    end else begin
                        load_rsp = 1'b1;
                        state_d  = S_RESP;
                    end
`else
                    load_rsp = 1'b1;
                    state_d  = S_RESP;
`endif
                end
            end
`ifdef LOAD_MISALIGN_SPLIT_EN
            S_REQ1: if (mem_req_ready) state_d = S_WAIT1;
            S_WAIT1: begin
                if (mem_rsp_valid) begin
                    load_rsp = 1'b1;
                    state_d  = S_RESP;
                end
            end
`endif
            S_RESP: if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

endmodule
